vga_plot_arbiter: RTL and testbench

- Per-frame scheduler that shares the single vga_adapter write port (x, y, colour, plot) between several drawing clients, e.g. the sky, the catcher and a future score display.
- On each frame tick it optionally clears the 160x120 screen, then grants each requesting client exclusive access in round-robin order until that client signals done.
- Replaces ad-hoc draw-enable muxing in the top level.
- Sits between the delay counter / game control FSM and the vga_adapter.

---
 rtl/vga_plot_arbiter.sv | 171 +++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// Per-frame arbiter sharing one vga_adapter write port between NUM_CLIENTS drawing clients.
// Define VGA_PLOT_ARB_CLEAR_EN to include the full-screen clear phase ahead of the client grants.
module vga_plot_arbiter #(
   parameter int unsigned NUM_CLIENTS      = 3,
   parameter logic [2:0]  BG_COLOR         = 3'b000,
   parameter int unsigned MAX_GRANT_CYCLES = 4096
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     frame_tick,
   input  logic [NUM_CLIENTS-1:0]   req,
   input  logic [8*NUM_CLIENTS-1:0] client_x,
   input  logic [7*NUM_CLIENTS-1:0] client_y,
   input  logic [3*NUM_CLIENTS-1:0] client_color,
   input  logic [NUM_CLIENTS-1:0]   client_plot,
   input  logic [NUM_CLIENTS-1:0]   client_done,
   output logic [NUM_CLIENTS-1:0]   grant,
   output logic [7:0]               x,
   output logic [6:0]               y,
   output logic [2:0]               color,
   output logic                     plot,
   output logic                     busy,
   output logic                     frame_done,
   output logic                     overrun,
   output logic                     timeout_err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_SCAN  = 3'd2;
   localparam logic [2:0] S_GRANT = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam int unsigned PW = $clog2(NUM_CLIENTS);
   localparam int unsigned WW = $clog2(MAX_GRANT_CYCLES);

   logic [2:0]             state;
   logic [NUM_CLIENTS-1:0] served;
   logic [NUM_CLIENTS-1:0] pending;
   logic [PW-1:0]          rr_ptr;
   logic [PW-1:0]          hit_idx;
   logic [PW-1:0]          rr_next;
   logic                   hit;
   logic [WW-1:0]          wd;
   int unsigned            j;

   logic [7:0] sel_x;
   logic [6:0] sel_y;
   logic [2:0] sel_color;
   logic       sel_plot;
   logic       sel_done;

   assign pending = req & ~served;

   // Rotating search: first pending client at or after rr_ptr, wrapping.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      j       = 0;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         j = 32'(rr_ptr) + i;
         if (j >= NUM_CLIENTS) j = j - NUM_CLIENTS;
         if (!hit && pending[j[PW-1:0]]) begin
            hit     = 1'b1;
            hit_idx = j[PW-1:0];
         end
      end
   end

   assign rr_next = (hit_idx == PW'(NUM_CLIENTS - 1)) ? '0 : hit_idx + 1'b1;

   always_comb begin
      sel_x     = '0;
      sel_y     = '0;
      sel_color = '0;
      sel_plot  = 1'b0;
      sel_done  = 1'b0;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         if (grant[i]) begin
            sel_x     = client_x[8*i +: 8];
            sel_y     = client_y[7*i +: 7];
            sel_color = client_color[3*i +: 3];
            sel_plot  = client_plot[i];
            sel_done  = client_done[i];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         served      <= '0;
         rr_ptr      <= '0;
         grant       <= '0;
         wd          <= '0;
         x           <= '0;
         y           <= '0;
         color       <= '0;
         plot        <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         plot       <= 1'b0;
         frame_done <= 1'b0;
         if (frame_tick && state != S_IDLE) overrun <= 1'b1;
         case (state)
            S_IDLE: if (frame_tick) begin
               served <= '0;
               busy   <= 1'b1;
               // Colour is seeded with the background at frame start; without the clear phase it is overwritten by the first grant.
               color  <= BG_COLOR;
`ifdef VGA_PLOT_ARB_CLEAR_EN
               state  <= S_CLEAR;
               x      <= '0;
               y      <= '0;
               plot   <= 1'b1;
`else
               state  <= S_SCAN;
`endif
            end
`ifdef VGA_PLOT_ARB_CLEAR_EN
            // x/y double as the sweep counter; the registered outputs are the current pixel.
            S_CLEAR: begin
               if (x == 8'd159 && y == 7'd119) begin
                  state <= S_SCAN;
               end else begin
                  plot <= 1'b1;
                  if (x == 8'd159) begin
                     x <= '0;
                     y <= y + 7'd1;
                  end else begin
                     x <= x + 8'd1;
                  end
               end
            end
`endif
            S_SCAN: begin
               if (hit) begin
                  grant           <= NUM_CLIENTS'(1) << hit_idx;
                  served[hit_idx] <= 1'b1;
                  rr_ptr          <= rr_next;
                  wd              <= '0;
                  state           <= S_GRANT;
               end else begin
                  frame_done <= 1'b1;
                  busy       <= 1'b0;
                  state      <= S_DONE;
               end
            end
            S_GRANT: begin
               x     <= sel_x;
               y     <= sel_y;
               color <= sel_color;
               plot  <= sel_plot;
               if (sel_done || wd == WW'(MAX_GRANT_CYCLES - 1)) begin
                  grant <= '0;
                  state <= S_SCAN;
                  if (!sel_done) timeout_err <= 1'b1;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: cycle-level reference model, directed frames and random traffic.
// Honours VGA_PLOT_ARB_CLEAR_EN in the same way as the design.
module tb_vga_plot_arbiter;

   localparam int         N    = 3;
   localparam int         MAXG = 16;
   localparam logic [2:0] BG   = 3'b000;
`ifdef VGA_PLOT_ARB_CLEAR_EN
   localparam int FRAME_BUDGET = 19400;
`else
   localparam int FRAME_BUDGET = 300;
`endif

   logic           clock = 1'b0;
   logic           reset;
   logic           frame_tick;
   logic [N-1:0]   req;
   logic [8*N-1:0] client_x;
   logic [7*N-1:0] client_y;
   logic [3*N-1:0] client_color;
   logic [N-1:0]   client_plot;
   logic [N-1:0]   client_done;
   logic [N-1:0]   grant;
   logic [7:0]     x;
   logic [6:0]     y;
   logic [2:0]     color;
   logic           plot, busy, frame_done, overrun, timeout_err;

   always #5 clock = ~clock;

   vga_plot_arbiter #(.NUM_CLIENTS(N), .BG_COLOR(BG), .MAX_GRANT_CYCLES(MAXG)) dut (
      .clock(clock), .reset(reset), .frame_tick(frame_tick), .req(req),
      .client_x(client_x), .client_y(client_y), .client_color(client_color),
      .client_plot(client_plot), .client_done(client_done), .grant(grant),
      .x(x), .y(y), .color(color), .plot(plot), .busy(busy),
      .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: phase of the frame plus the spec-level bookkeeping.
   typedef enum {P_IDLE, P_CLEAR, P_SCAN, P_GRANT, P_DONE} phase_t;
   phase_t     ph = P_IDLE;
   int         rr = 0, owner = -1, wd = 0, clr_pos = 0;
   bit         served [N];
   logic [N-1:0] exp_grant = '0;
   logic [7:0] exp_x = '0;
   logic [6:0] exp_y = '0;
   logic [2:0] exp_c = '0;
   logic       exp_plot = 0, exp_busy = 0, exp_fd = 0, exp_ovr = 0, exp_to = 0, exp_xyc = 0;

   task automatic model_step();
      bit found;
      int k;
      exp_xyc = 0;
      if (reset) begin
         ph = P_IDLE; rr = 0; owner = -1; wd = 0;
         foreach (served[i]) served[i] = 0;
         exp_grant = '0; exp_x = '0; exp_y = '0; exp_c = '0;
         exp_plot = 0; exp_busy = 0; exp_fd = 0; exp_ovr = 0; exp_to = 0; exp_xyc = 1;
         return;
      end
      exp_plot = 0;
      exp_fd   = 0;
      if (frame_tick && ph != P_IDLE) exp_ovr = 1;
      case (ph)
         P_IDLE: if (frame_tick) begin
            foreach (served[i]) served[i] = 0;
            exp_busy = 1;
`ifdef VGA_PLOT_ARB_CLEAR_EN
            ph = P_CLEAR; clr_pos = 0;
            exp_x = 0; exp_y = 0; exp_c = BG; exp_plot = 1;
`else
            ph = P_SCAN;
`endif
         end
         P_CLEAR: begin
            if (clr_pos == 160*120 - 1) ph = P_SCAN;
            else begin
               clr_pos++;
               exp_x = 8'(clr_pos % 160); exp_y = 7'(clr_pos / 160); exp_c = BG; exp_plot = 1;
            end
         end
         P_SCAN: begin
            found = 0;
            for (int i = 0; i < N; i++) begin
               k = (rr + i) % N;
               if (!found && req[k] && !served[k]) begin found = 1; owner = k; end
            end
            if (found) begin
               served[owner] = 1; rr = (owner + 1) % N; wd = 0;
               exp_grant = N'(1) << owner; ph = P_GRANT;
            end else begin
               ph = P_DONE; exp_fd = 1; exp_busy = 0;
            end
         end
         P_GRANT: begin
            exp_x = client_x[8*owner +: 8]; exp_y = client_y[7*owner +: 7];
            exp_c = client_color[3*owner +: 3]; exp_plot = client_plot[owner];
            if (client_done[owner]) begin
               exp_grant = '0; ph = P_SCAN;
            end else if (wd == MAXG - 1) begin
               exp_grant = '0; ph = P_SCAN; exp_to = 1;
            end else wd++;
         end
         P_DONE: ph = P_IDLE;
      endcase
      if (exp_plot) exp_xyc = 1;
   endtask

   // Client behaviour: random junk, well-behaved (5 plots then done), or client 0 stuck.
   localparam int M_RAND = 0, M_GOOD = 1, M_STUCK0 = 2;
   int mode = M_GOOD;
   int cnt [N];

   task automatic drive_clients();
      for (int i = 0; i < N; i++) begin
         client_x[8*i +: 8]     = 8'($urandom_range(0, 159));
         client_y[7*i +: 7]     = 7'($urandom_range(0, 119));
         client_color[3*i +: 3] = 3'($urandom);
         if (mode != M_RAND && grant[i]) begin
            if (mode == M_STUCK0 && i == 0) begin
               client_plot[i] = 1'($urandom); client_done[i] = 1'b0;
            end else if (cnt[i] < 5) begin
               client_plot[i] = 1'b1; client_done[i] = 1'b0; cnt[i]++;
            end else begin
               client_plot[i] = 1'b0; client_done[i] = 1'b1;
            end
         end else begin
            cnt[i] = 0;
            client_plot[i] = 1'($urandom);
            client_done[i] = ($urandom_range(0, 5) == 0);
         end
      end
   endtask

   int         obs[$];
   logic [N-1:0] prev_grant = '0;
   int         g0_cycles = 0, plot_count = 0, frame_len = 0;
   logic [14:0] first_px = '0, last_px = '0;

   task automatic cycle();
      @(posedge clock);
      model_step();
      #1;
      check("grant", grant, exp_grant);
      check("plot", plot, exp_plot);
      check("busy", busy, exp_busy);
      check("frame_done", frame_done, exp_fd);
      check("overrun", overrun, exp_ovr);
      check("timeout_err", timeout_err, exp_to);
      if (exp_xyc) begin
         check("x", x, exp_x);
         check("y", y, exp_y);
         check("color", color, exp_c);
      end
      if (grant != 0 && prev_grant == 0)
         for (int i = 0; i < N; i++) if (grant[i]) obs.push_back(i);
      prev_grant = grant;
      if (grant[0]) g0_cycles++;
      if (plot) begin
         if (plot_count == 0) first_px = {x, y};
         last_px = {x, y};
         plot_count++;
      end
      drive_clients();
   endtask

   task automatic wait_frame_done();
      bit seen = 0;
      for (int i = 0; i < FRAME_BUDGET && !seen; i++) begin
         cycle();
         if (frame_done) begin seen = 1; frame_len = i + 1; end
      end
      check("frame_done_seen", seen, 1);
      cycle();
   endtask

   task automatic run_frame(input logic [N-1:0] r);
      req = r; frame_tick = 1; cycle(); frame_tick = 0;
      wait_frame_done();
   endtask

   initial begin
      reset = 1; frame_tick = 0; req = '0; client_plot = '0; client_done = '0;
      client_x = '0; client_y = '0; client_color = '0;
      foreach (cnt[i]) cnt[i] = 0;
      drive_clients();
      cycle(); cycle();
      check("rst_busy", busy, 0);
      check("rst_grant", grant, 0);
      reset = 0;
      cycle();

      // Empty frame: only the clear sweep (if present) plots.
      plot_count = 0;
      run_frame('0);
`ifdef VGA_PLOT_ARB_CLEAR_EN
      check("clear_count", plot_count, 160*120);
      check("clear_first", first_px, {8'd0, 7'd0});
      check("clear_last", last_px, {8'd159, 7'd119});
      check("clear_len_ok", (frame_len >= 19201 && frame_len <= 19203), 1);
      obs.delete();
      run_frame(3'b111);
      check("rr1_size", obs.size(), 3);
      for (int i = 0; i < obs.size(); i++) check("rr1_order", obs[i], i % 3);
`else
      check("empty_count", plot_count, 0);
      check("empty_len", frame_len, 1);

      // Two full frames with every client requesting: 0,1,2 each time.
      obs.delete();
      run_frame(3'b111);
      run_frame(3'b111);
      check("rr_size", obs.size(), 6);
      for (int i = 0; i < obs.size(); i++) check("rr_order", obs[i], i % 3);

      // Leave rr at 1, then req 101 must serve 2 before 0.
      run_frame(3'b001);
      obs.delete();
      run_frame(3'b101);
      check("part_size", obs.size(), 2);
      if (obs.size() == 2) begin
         check("part_first", obs[0], 2);
         check("part_second", obs[1], 0);
      end

      // Watchdog: rr back to 0, client 0 never finishes.
      run_frame(3'b100);
      obs.delete(); g0_cycles = 0; mode = M_STUCK0;
      run_frame(3'b011);
      check("wd_grant_len", g0_cycles, MAXG);
      check("wd_flag", timeout_err, 1);
      check("wd_size", obs.size(), 2);
      if (obs.size() == 2) check("wd_next", obs[1], 1);
      mode = M_GOOD;
      run_frame(3'b111);
      check("wd_sticky", timeout_err, 1);

      // Overrun: second tick mid-frame does not restart it.
      obs.delete();
      req = 3'b111; frame_tick = 1; cycle(); frame_tick = 0;
      repeat (4) cycle();
      frame_tick = 1; cycle(); frame_tick = 0;
      wait_frame_done();
      check("ovr_flag", overrun, 1);
      check("ovr_size", obs.size(), 3);

      // Reset while a client holds the port.
      begin
         bit granted = 0;
         req = 3'b111; frame_tick = 1; cycle(); frame_tick = 0;
         for (int i = 0; i < 20 && !granted; i++) begin cycle(); if (grant != 0) granted = 1; end
         check("rg_granted", granted, 1);
         cycle();
         reset = 1; cycle(); reset = 0;
         check("rg_grant", grant, 0);
         check("rg_plot", plot, 0);
         check("rg_busy", busy, 0);
         check("rg_ovr", overrun, 0);
         check("rg_to", timeout_err, 0);
         cycle();
         obs.delete();
         run_frame(3'b111);
         check("rg_restart", (obs.size() > 0) ? obs[0] : -1, 0);
      end

      // Random traffic: noisy clients, random req, ticks and rare resets.
      mode = M_RAND;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 39) == 0) req = N'($urandom);
         frame_tick = ($urandom_range(0, 24) == 0);
         reset      = ($urandom_range(0, 799) == 0);
         cycle();
      end
      frame_tick = 0; reset = 0;
      repeat (4) cycle();
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
